// File: rtl/c_seq.sv
// c_seq: multi-cycle admission controller for unary / thermometer codes.
// A W-bit vector is accepted in IDLE, scanned LSB-first B bits per cycle in
// SCAN while the number of 0/1 transitions (saturating at 2) and the number
// of ones are accumulated, and the verdict plus code length is presented in
// DONE until the consumer accepts it.
module c_seq #(
    parameter int W                     = 16,
    parameter int B                     = 4,
    parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_in_vld,
    input  logic [W-1:0]           i_in_x,
    output logic                   o_in_rdy,
    output logic                   o_out_vld,
    input  logic                   i_out_rdy,
    output logic                   o_out_is_unary,
    output logic                   o_out_is_compliment,
    output logic [$clog2(W+1)-1:0] o_out_len,
    output logic                   o_busy
);

    // Width of the length / ones counter, number of chunks, chunk counter
    // width, and the width used to add up transitions without overflow.
    localparam int LW   = $clog2(W + 1);
    localparam int NCH  = W / B;
    localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW   = $clog2(W + 3);

    localparam logic COMP_EN = (P_ADMIT_COMPLIMENT_EN != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Scan datapath state.
    logic [W-1:0]    shift_reg;
    logic [CNTW-1:0] chunk_cnt;
    logic [1:0]      trans_cnt;
    logic [LW-1:0]   ones_cnt;
    logic            prev_msb;
    logic            x_lsb;
    logic            x_msb;

    // Registered result presented during DONE.
    logic            res_unary;
    logic            res_comp;
    logic [LW-1:0]   res_len;

    // Combinational per-chunk values.
    logic [B-1:0]    chunk;
    logic [SW-1:0]   chunk_edges;
    logic [SW-1:0]   trans_sum;
    logic [1:0]      trans_next;
    logic [LW-1:0]   ones_next;
    logic            last_chunk;
    logic            verdict_unary;
    logic [LW-1:0]   verdict_len;

    // Count the edges in the current chunk (including the seam to the
    // previous chunk's MSB), saturate the running transition count at 2 and
    // accumulate the ones.
    always_comb begin
        chunk       = shift_reg[B-1:0];
        chunk_edges = '0;
        for (int i = 0; i < B - 1; i++) begin
            chunk_edges = chunk_edges + SW'(chunk[i] ^ chunk[i+1]);
        end
        if (chunk_cnt != '0) begin
            chunk_edges = chunk_edges + SW'(prev_msb ^ chunk[0]);
        end
        trans_sum  = SW'(trans_cnt) + chunk_edges;
        trans_next = (trans_sum >= SW'(2)) ? 2'd2 : trans_sum[1:0];
        ones_next  = ones_cnt;
        for (int i = 0; i < B; i++) begin
            ones_next = ones_next + LW'(chunk[i]);
        end
        last_chunk = (chunk_cnt == CNTW'(NCH - 1));
    end

    // Final verdict from the transition count and the two end bits: zero
    // transitions is all-zeros (standard) or all-ones (complement only);
    // one transition is a standard code when it starts with ones and a
    // complemented code when it starts with zeros.
    always_comb begin
        verdict_unary = ((trans_next == 2'd0) & ~x_lsb)
                      | ((trans_next == 2'd0) &  x_lsb & COMP_EN)
                      | ((trans_next == 2'd1) &  x_lsb & ~x_msb)
                      | ((trans_next == 2'd1) & ~x_lsb &  x_msb & COMP_EN);
        verdict_len   = '0;
        if (verdict_unary) begin
            verdict_len = x_msb ? (LW'(W) - ones_next) : ones_next;
        end
    end

    // State register; reset discards any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> SCAN on a request, SCAN -> DONE after the
    // last chunk, DONE -> IDLE once the result is taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (i_in_vld)   state_next = SCAN;
            SCAN: if (last_chunk) state_next = DONE;
            DONE: if (i_out_rdy)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Handshake and result outputs; ready is suppressed while reset is held
    // so no request looks accepted during the reset cycle.
    always_comb begin
        o_in_rdy            = (state == IDLE) & ~i_rst;
        o_out_vld           = (state == DONE);
        o_busy              = (state != IDLE);
        o_out_is_unary      = res_unary;
        o_out_is_compliment = res_comp;
        o_out_len           = res_len;
    end

    // Scan datapath: capture the vector on accept, consume one chunk per
    // SCAN cycle, and latch the verdict when the last chunk is consumed so
    // the result stays frozen throughout DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_reg <= '0;
            chunk_cnt <= '0;
            trans_cnt <= '0;
            ones_cnt  <= '0;
            prev_msb  <= 1'b0;
            x_lsb     <= 1'b0;
            x_msb     <= 1'b0;
            res_unary <= 1'b0;
            res_comp  <= 1'b0;
            res_len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_in_vld) begin
                        shift_reg <= i_in_x;
                        chunk_cnt <= '0;
                        trans_cnt <= '0;
                        ones_cnt  <= '0;
                        prev_msb  <= 1'b0;
                        x_lsb     <= i_in_x[0];
                        x_msb     <= i_in_x[W-1];
                        res_unary <= 1'b0;
                        res_comp  <= 1'b0;
                        res_len   <= '0;
                    end
                end
                SCAN: begin
                    shift_reg <= shift_reg >> B;
                    chunk_cnt <= chunk_cnt + CNTW'(1);
                    trans_cnt <= trans_next;
                    ones_cnt  <= ones_next;
                    prev_msb  <= chunk[B-1];
                    if (last_chunk) begin
                        res_unary <= verdict_unary;
                        res_comp  <= COMP_EN & x_msb;
                        res_len   <= verdict_len;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c_seq.sv
// tb_c_seq: directed bench for c_seq. Five instances share the request and
// result handshake: B=4 with and without complement admission, and B=1, 2
// and 16 with complement admission. Every result is compared against hand
// values and against a reference built from the code definition.
module tb_c_seq;

    localparam int W  = 16;
    localparam int LW = 5;
    localparam int ND = 5;

    logic          clk;
    logic          rst;
    logic          in_vld;
    logic [W-1:0]  in_x;
    logic          out_rdy;

    logic [ND-1:0] in_rdy_v;
    logic [ND-1:0] out_vld_v;
    logic [ND-1:0] unary_v;
    logic [ND-1:0] comp_v;
    logic [ND-1:0] busy_v;
    logic [LW-1:0] len_v [ND];

    int            check_count;
    int            fail_count;

    int            got_lat   [ND];
    logic          got_unary [ND];
    logic          got_comp  [ND];
    logic [LW-1:0] got_len   [ND];

    int            exp_lat   [ND] = '{5, 5, 17, 9, 2};
    bit            dut_comp  [ND] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Directed vectors: {unary, compliment, len} for COMP_EN=1 and COMP_EN=0.
    logic [W-1:0]  dir_x     [9] = '{16'h00FF, 16'hFFF0, 16'h0000, 16'hFFFF,
                                     16'h00F7, 16'h0F0F, 16'h7FFF, 16'h8000,
                                     16'h0001};
    logic [6:0]    exp_main  [9] = '{{1'b1, 1'b0, 5'd8},  {1'b1, 1'b1, 5'd4},
                                     {1'b1, 1'b0, 5'd0},  {1'b1, 1'b1, 5'd0},
                                     {1'b0, 1'b0, 5'd0},  {1'b0, 1'b0, 5'd0},
                                     {1'b1, 1'b0, 5'd15}, {1'b1, 1'b1, 5'd15},
                                     {1'b1, 1'b0, 5'd1}};
    logic [6:0]    exp_nc    [9] = '{{1'b1, 1'b0, 5'd8},  {1'b0, 1'b0, 5'd0},
                                     {1'b1, 1'b0, 5'd0},  {1'b0, 1'b0, 5'd0},
                                     {1'b0, 1'b0, 5'd0},  {1'b0, 1'b0, 5'd0},
                                     {1'b1, 1'b0, 5'd15}, {1'b0, 1'b0, 5'd0},
                                     {1'b1, 1'b0, 5'd1}};

    c_seq #(.W(W), .B(4), .P_ADMIT_COMPLIMENT_EN(1)) dut_main (
        .i_clk(clk), .i_rst(rst), .i_in_vld(in_vld), .i_in_x(in_x),
        .o_in_rdy(in_rdy_v[0]), .o_out_vld(out_vld_v[0]), .i_out_rdy(out_rdy),
        .o_out_is_unary(unary_v[0]), .o_out_is_compliment(comp_v[0]),
        .o_out_len(len_v[0]), .o_busy(busy_v[0])
    );

    c_seq #(.W(W), .B(4), .P_ADMIT_COMPLIMENT_EN(0)) dut_nc (
        .i_clk(clk), .i_rst(rst), .i_in_vld(in_vld), .i_in_x(in_x),
        .o_in_rdy(in_rdy_v[1]), .o_out_vld(out_vld_v[1]), .i_out_rdy(out_rdy),
        .o_out_is_unary(unary_v[1]), .o_out_is_compliment(comp_v[1]),
        .o_out_len(len_v[1]), .o_busy(busy_v[1])
    );

    c_seq #(.W(W), .B(1), .P_ADMIT_COMPLIMENT_EN(1)) dut_b1 (
        .i_clk(clk), .i_rst(rst), .i_in_vld(in_vld), .i_in_x(in_x),
        .o_in_rdy(in_rdy_v[2]), .o_out_vld(out_vld_v[2]), .i_out_rdy(out_rdy),
        .o_out_is_unary(unary_v[2]), .o_out_is_compliment(comp_v[2]),
        .o_out_len(len_v[2]), .o_busy(busy_v[2])
    );

    c_seq #(.W(W), .B(2), .P_ADMIT_COMPLIMENT_EN(1)) dut_b2 (
        .i_clk(clk), .i_rst(rst), .i_in_vld(in_vld), .i_in_x(in_x),
        .o_in_rdy(in_rdy_v[3]), .o_out_vld(out_vld_v[3]), .i_out_rdy(out_rdy),
        .o_out_is_unary(unary_v[3]), .o_out_is_compliment(comp_v[3]),
        .o_out_len(len_v[3]), .o_busy(busy_v[3])
    );

    c_seq #(.W(W), .B(16), .P_ADMIT_COMPLIMENT_EN(1)) dut_b16 (
        .i_clk(clk), .i_rst(rst), .i_in_vld(in_vld), .i_in_x(in_x),
        .o_in_rdy(in_rdy_v[4]), .o_out_vld(out_vld_v[4]), .i_out_rdy(out_rdy),
        .o_out_is_unary(unary_v[4]), .o_out_is_compliment(comp_v[4]),
        .o_out_len(len_v[4]), .o_busy(busy_v[4])
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count a comparison and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference straight from the code definition: x is 2^k-1, or (when
    // complements are admitted) ~(2^k-1), for some k in 0..W-1.
    function automatic logic [6:0] refModel(input logic [W-1:0] x, input bit p);
        logic [W-1:0]  code;
        logic          u;
        logic [LW-1:0] len;
        u   = 1'b0;
        len = '0;
        for (int k = 0; k < W; k++) begin
            code = W'((32'd1 << k) - 32'd1);
            if (x == code) begin
                u   = 1'b1;
                len = LW'(k);
            end
            if (p && (x == ~code)) begin
                u   = 1'b1;
                len = LW'(k);
            end
        end
        return {u, p & x[W-1], len};
    endfunction

    // Present one vector to all instances and capture each result along
    // with the cycle (counted from the accept cycle) it appeared in.
    task automatic applyStimulus(input logic [W-1:0] x);
        logic [ND-1:0] seen;
        @(negedge clk);
        checkOutput("in_rdy_before_accept", 32'(in_rdy_v), 32'h1F);
        in_vld = 1'b1;
        in_x   = x;
        @(negedge clk);
        in_vld = 1'b0;
        in_x   = ~x;
        seen   = '0;
        for (int k = 0; k < ND; k++) got_lat[k] = 0;
        for (int c = 1; c <= 40 && seen != '1; c++) begin
            for (int k = 0; k < ND; k++) begin
                if (!seen[k] && out_vld_v[k]) begin
                    seen[k]      = 1'b1;
                    got_lat[k]   = c;
                    got_unary[k] = unary_v[k];
                    got_comp[k]  = comp_v[k];
                    got_len[k]   = len_v[k];
                end
            end
            if (seen != '1) @(negedge clk);
        end
    endtask

    // Compare every instance's captured result against the reference.
    task automatic verifyResult(input logic [W-1:0] x);
        logic [6:0] ref_val;
        for (int k = 0; k < ND; k++) begin
            ref_val = refModel(x, dut_comp[k]);
            checkOutput($sformatf("dut%0d_latency x=%04h", k, x), 32'(got_lat[k]), 32'(exp_lat[k]));
            checkOutput($sformatf("dut%0d_unary x=%04h", k, x), 32'(got_unary[k]), 32'(ref_val[6]));
            checkOutput($sformatf("dut%0d_comp x=%04h", k, x), 32'(got_comp[k]), 32'(ref_val[5]));
            checkOutput($sformatf("dut%0d_len x=%04h", k, x), 32'(got_len[k]), 32'(ref_val[4:0]));
        end
    endtask

    initial begin
        logic [W-1:0] rx;
        logic         seen_vld;
        check_count = 0;
        fail_count  = 0;
        out_rdy     = 1'b1;

        // Reset with a request pending: it must be ignored.
        rst    = 1'b1;
        in_vld = 1'b1;
        in_x   = 16'hFFFF;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_rdy", 32'(in_rdy_v), 32'h0);
        checkOutput("reset_out_vld", 32'(out_vld_v), 32'h0);
        checkOutput("reset_busy", 32'(busy_v), 32'h0);
        checkOutput("reset_unary", 32'(unary_v), 32'h0);
        checkOutput("reset_comp", 32'(comp_v), 32'h0);
        checkOutput("reset_len", 32'(len_v[0]), 32'h0);
        rst    = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_rdy", 32'(in_rdy_v[0]), 32'h1);
        checkOutput("post_reset_busy", 32'(busy_v[0]), 32'h0);

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(dir_x[i]);
            verifyResult(dir_x[i]);
            checkOutput($sformatf("dir_main x=%04h", dir_x[i]),
                        32'({got_unary[0], got_comp[0], got_len[0]}), 32'(exp_main[i]));
            checkOutput($sformatf("dir_nocomp x=%04h", dir_x[i]),
                        32'({got_unary[1], got_comp[1], got_len[1]}), 32'(exp_nc[i]));
        end

        // Random vectors and random (possibly complemented) codes across the
        // B sweep.
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                rx = W'($urandom);
            end else begin
                rx = W'((32'd1 << $urandom_range(0, W - 1)) - 32'd1);
                if ($urandom_range(0, 1) == 1) rx = ~rx;
            end
            applyStimulus(rx);
            verifyResult(rx);
        end

        // Back-pressure: result must hold for 10 cycles with no new accept.
        out_rdy = 1'b0;
        @(negedge clk);
        in_vld = 1'b1;
        in_x   = 16'h003F;
        @(negedge clk);
        in_vld = 1'b0;
        in_x   = 16'hAAAA;
        repeat (4) @(negedge clk);
        checkOutput("hold_first_vld", 32'(out_vld_v[0]), 32'h1);
        checkOutput("hold_first_result", 32'({unary_v[0], comp_v[0], len_v[0]}),
                    32'({1'b1, 1'b0, 5'd6}));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_vld_c%0d", c), 32'(out_vld_v[0]), 32'h1);
            checkOutput($sformatf("hold_result_c%0d", c),
                        32'({unary_v[0], comp_v[0], len_v[0]}), 32'({1'b1, 1'b0, 5'd6}));
            checkOutput($sformatf("hold_in_rdy_c%0d", c), 32'(in_rdy_v[0]), 32'h0);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        checkOutput("release_in_rdy", 32'(in_rdy_v[0]), 32'h1);
        checkOutput("release_out_vld", 32'(out_vld_v[0]), 32'h0);
        in_vld = 1'b1;
        in_x   = 16'hFFFC;
        @(negedge clk);
        in_vld = 1'b0;
        checkOutput("reaccept_busy", 32'(busy_v[0]), 32'h1);
        repeat (4) @(negedge clk);
        checkOutput("reaccept_vld", 32'(out_vld_v[0]), 32'h1);
        checkOutput("reaccept_result", 32'({unary_v[0], comp_v[0], len_v[0]}),
                    32'({1'b1, 1'b1, 5'd2}));

        // Clean every instance back to IDLE.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset during the second SCAN cycle discards the transaction.
        in_vld = 1'b1;
        in_x   = 16'h00FF;
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midscan_reset_in_rdy", 32'(in_rdy_v[0]), 32'h0);
        checkOutput("midscan_reset_busy", 32'(busy_v[0]), 32'h0);
        rst      = 1'b0;
        seen_vld = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_vld_v[0]) seen_vld = 1'b1;
        end
        checkOutput("midscan_no_result", 32'(seen_vld), 32'h0);
        applyStimulus(16'h0001);
        verifyResult(16'h0001);
        checkOutput("after_reset_x0001", 32'({got_unary[0], got_comp[0], got_len[0]}),
                    32'({1'b1, 1'b0, 5'd1}));

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
